// File: rtl/bootrom_bus_bridge.sv
// PicoRV32 native-bus bridge to the 8 KB bootloader ROM: window decode, one-cycle read latency, write-fault counting.
// Optional data-read lock enabled by defining BOOTROM_LOCK_EN.
module bootrom_bus_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0004_0000,
  parameter int          FAULT_W   = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               mem_valid,
  input  logic               mem_instr,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_wstrb,
  output logic               sel,
  output logic               mem_ready,
  output logic [31:0]        mem_rdata,
  output logic [12:0]        rom_addr,
  output logic               rom_enable,
  input  logic [31:0]        rom_rdata,
  output logic               wr_fault,
  output logic [FAULT_W-1:0] fault_count,
  output logic               locked
);

  typedef enum logic [1:0] {S_IDLE, S_RESP, S_WACK} state_e;

  localparam logic [31:0] LOCK_MAGIC = 32'h4C4F_434B;
  localparam logic [12:0] LOCK_OFFS  = 13'h1FFC;
`ifdef BOOTROM_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [FAULT_W-1:0] fault_count_q, fault_count_d;
  logic               wr_fault_q, wr_fault_d;
  logic               locked_q;
  logic               rd_req, wr_req, lock_hit, lock_cmd;

  assign sel      = mem_valid && (mem_addr[31:13] == BASE_ADDR[31:13]);
  assign rd_req   = sel && (mem_wstrb == 4'h0);
  assign wr_req   = sel && (mem_wstrb != 4'h0);
  assign lock_hit = wr_req && (mem_addr[12:0] == LOCK_OFFS) && (mem_wstrb == 4'hF)
                    && (mem_wdata == LOCK_MAGIC);
  assign lock_cmd = LOCK_EN && lock_hit;
  assign rom_addr = mem_addr[12:0];

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    fault_count_d = fault_count_q;
    wr_fault_d    = 1'b0;
    rom_enable    = 1'b0;
    mem_ready     = 1'b0;
    mem_rdata     = 32'h0;
    // Reset is synchronous, so the decode is gated to keep outputs quiet during the reset cycle itself.
    if (resetn) begin
      case (state_q)
        S_IDLE: begin
          if (rd_req) begin
            rom_enable = 1'b1;
            state_d    = S_RESP;
          end else if (wr_req) begin
            state_d = S_WACK;
            if (!lock_cmd) begin
              wr_fault_d = 1'b1;
              if (fault_count_q != {FAULT_W{1'b1}}) fault_count_d = fault_count_q + FAULT_W'(1);
            end
          end
        end
        S_RESP: begin
          if (mem_valid) begin
            mem_ready = 1'b1;
            mem_rdata = (locked_q && !mem_instr) ? 32'h0 : rom_rdata;
          end
          state_d = S_IDLE;
        end
        S_WACK: begin
          mem_ready = mem_valid;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      fault_count_q <= '0;
      wr_fault_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      fault_count_q <= fault_count_d;
      wr_fault_q    <= wr_fault_d;
    end
  end

`ifdef BOOTROM_LOCK_EN
  // Set on the accepting edge so locked is already visible in the WACK cycle; only reset clears it.
  always_ff @(posedge clk) begin
    if (!resetn) locked_q <= 1'b0;
    else if (state_q == S_IDLE && lock_cmd) locked_q <= 1'b1;
  end
`else
  assign locked_q = 1'b0;
`endif

  assign wr_fault    = wr_fault_q;
  assign fault_count = fault_count_q;
  assign locked      = locked_q;

endmodule
